out_line: RTL and testbench
===========================

// Module: out_line
// PURPOSE
//  MIX character output unit (line printer / card punch over UART): the transmit-side counterpart of the input unit.
//  On CPU start it fetches WORDS consecutive memory words via the request/load handshake.
//  Each 30-bit word is unpacked into five 6-bit MIX codes, MSB field first; each code is translated to ASCII.
//  The characters go out as 8N1 serial on tx, and every block ends with CR LF.
//  Sits beside the input unit on the CPU I/O bus; same start/stop/busy contract toward the CPU.
// PARAMETERS
//  WORDS         14    words per block (1..63)
//  CLKS_PER_BIT  217   clk cycles per UART bit (>=2)
// PORTS
//  clk        in   1   system clock; single clock domain
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   CPU issues OUT; 1-cycle pulse
//  addressin  in   12  first memory address of block, valid with start
//  in         in   30  memory word; valid when load=1
//  load       in   1   CPU supplies word for addressout; 1-cycle pulse, only while request=1
//  addressout out  12  address of word requested
//  request    out  1   unit wants word at addressout
//  stop       out  1   1-cycle pulse: CPU may resume
//  busy       out  1   block transfer in progress
//  tx         out  1   UART serial out, idle high
// BEHAVIOUR
//  Reset values (asserted asynchronously):
//   - busy=0, request=0, stop=0, addressout=0, tx=1.
//   - All counters, the pending flag, address_next, the holding register and the shift register clear.
//  Start, idle (busy=0):
//   - Next cycle: busy=1, stop=1 (one cycle), addressout=addressin, request=1.
//  Start, busy (busy=1):
//   - Latch address_next=addressin and set pending=1; no stop pulse.
//   - A further start while pending=1 is ignored (CPU is blocked, so this is illegal).
//  Fetch:
//   - One holding register (hold, hold_full).
//   - request=1 whenever hold_full=0 and words_fetched<WORDS.
//   - On load&request: hold<=in, hold_full<=1, request<=0, addressout<=addressout+1 (12-bit wrap 4095->0).
//  Serialiser:
//   - When the char shift register is empty and hold_full=1: move hold into the shifter and clear hold_full.
//   - The next fetch can therefore overlap transmission.
//   - Emit fields [29:24],[23:18],...,[5:0] in that order.
//   - Each char starts the UART the cycle after the previous stop bit ends, giving back-to-back frames.
//   - If load is late, tx idles high and no char is repeated or dropped.
//  Code map, MIX -> ASCII:
//   - 0 -> ' '
//   - 1-9 -> 'A'-'I'; 11-19 -> 'J'-'R'; 22-29 -> 'S'-'Z'
//   - 30-39 -> '0'-'9'
//   - 40 '.', 41 ',', 42 '(', 43 ')', 44 '+', 45 '-', 46 '*', 47 '/'
//   - 48 '=', 49 '$', 50 '<', 51 '>', 52 '@', 53 ';', 54 ':', 55 0x27
//   - 10, 20, 21, 56-63 -> '?' (0x3F)
//  End of line:
//   - After the 5th char of word WORDS, send 0x0D then 0x0A.
//  UART frame:
//   - Start bit 0, 8 data bits LSB first, 1 stop bit; each bit held exactly CLKS_PER_BIT cycles.
//   - A frame is 10*CLKS_PER_BIT cycles.
//  Block completion (last cycle of the LF stop bit):
//   - pending=0: next cycle busy=0; no stop pulse.
//   - pending=1: next cycle stop=1 (one cycle), pending=0, addressout=address_next, counters clear, request=1.
//     busy stays 1.
//   - start in the completion cycle while busy=1 is taken as queued and serviced at once: stop pulses the following cycle.
//  FSM states:
//   - IDLE -> (start) -> RUN
//   - RUN -> (5*WORDS chars sent) -> CR
//   - CR -> LF
//   - LF -> IDLE, or RUN if pending
//  Reset mid-frame: tx returns high immediately; the partial frame is abandoned and no recovery is attempted.
// TESTING  (CLKS_PER_BIT=4, WORDS=2 unless stated)
//  1 Reset asserted mid-sim -> tx=1, busy=0, request=0, stop=0 without waiting for a clk edge.
//  2 start, addressin=100; mem[100]={1,2,3,0,30}, mem[101]={31,32,33,34,35}
//    -> stop pulses once, 1 cycle after start; addressout 100 then 101.
//    -> tx bytes 41 42 43 20 30 31 32 33 34 35 0D 0A, each frame 40 cycles.
//    -> busy falls 1 cycle after LF stop bit.
//  3 word {10,45,48,55,63} -> tx 3F 2D 3D 27 3F.
//  4 second start, addressin=200, mid-block
//    -> no stop until LF ends, then stop pulses 1 cycle; addressout=200.
//    -> busy never drops; new block follows without an idle frame.
//  5 load withheld 300 cycles on word 2
//    -> request held, tx high after char 5, transmission resumes with char 6 exactly once.
//  6 reset during 3rd data bit, then start addressin=4095, WORDS=2
//    -> clean restart; addresses 4095 then 0.

Source files
------------

// File: rtl/out_line.sv
// out_line: MIX character output unit (line printer / card punch over UART).
// On start it fetches WORDS consecutive memory words through the request/load
// handshake. Each 30-bit word is split into five 6-bit MIX codes, MSB field
// first, and each code is translated to ASCII. The characters go out as 8N1
// serial on tx, and every block ends with CR LF.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   start       CPU issues OUT (1-cycle pulse)
//   addressin   first memory address of the block, valid with start
//   in          memory word, valid while load=1
//   load        CPU supplies the word for addressout (1-cycle pulse)
//   addressout  address of the word requested
//   request     unit wants the word at addressout
//   stop        1-cycle pulse: CPU may resume
//   busy        block transfer in progress
//   tx          UART serial out, idle high
module out_line #(
  parameter int unsigned WORDS        = 14,
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] addressin,
  input  logic [29:0] in,
  input  logic        load,
  output logic [11:0] addressout,
  output logic        request,
  output logic        stop,
  output logic        busy,
  output logic        tx
);

  localparam int unsigned Chars = 5 * WORDS;
  localparam int unsigned WordW = $clog2(WORDS + 1);
  localparam int unsigned CharW = $clog2(Chars + 1);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {StIdle, StRun, StCr, StLf} state_e;

  state_e           state_q, state_d;
  logic [11:0]      addressout_q, address_next_q;
  logic             pending_q, stop_q;
  logic [WordW-1:0] words_fetched_q;
  logic [CharW-1:0] chars_sent_q;
  logic [29:0]      hold_q, shift_q;
  logic             hold_full_q;
  logic [2:0]       shift_cnt_q;
  logic             tx_active_q, tx_q;
  logic [3:0]       bit_cnt_q;
  logic [BaudW-1:0] baud_cnt_q;
  logic [7:0]       data_q;

  logic       frame_done, uart_free, take_load, refill, block_done, start_queued;
  logic       launch, launch_data;
  logic [7:0] launch_byte;

  function automatic logic [7:0] mix_to_ascii(input logic [5:0] code);
    logic [7:0] c;
    logic [7:0] r;
    c = {2'b00, code};
    r = 8'h3F;
    if (code == 6'd0) begin
      r = 8'h20;
    end else if (code <= 6'd9) begin
      r = 8'h40 + c;
    end else if (code >= 6'd11 && code <= 6'd19) begin
      r = 8'h3F + c;
    end else if (code >= 6'd22 && code <= 6'd29) begin
      r = 8'h3D + c;
    end else if (code >= 6'd30 && code <= 6'd39) begin
      r = c + 8'h12;
    end else begin
      case (code)
        6'd40:   r = 8'h2E;
        6'd41:   r = 8'h2C;
        6'd42:   r = 8'h28;
        6'd43:   r = 8'h29;
        6'd44:   r = 8'h2B;
        6'd45:   r = 8'h2D;
        6'd46:   r = 8'h2A;
        6'd47:   r = 8'h2F;
        6'd48:   r = 8'h3D;
        6'd49:   r = 8'h24;
        6'd50:   r = 8'h3C;
        6'd51:   r = 8'h3E;
        6'd52:   r = 8'h40;
        6'd53:   r = 8'h3B;
        6'd54:   r = 8'h3A;
        6'd55:   r = 8'h27;
        default: r = 8'h3F;
      endcase
    end
    return r;
  endfunction

  assign busy       = (state_q != StIdle);
  assign stop       = stop_q;
  assign tx         = tx_q;
  assign addressout = addressout_q;
  assign request    = busy && !hold_full_q && (words_fetched_q < WordW'(WORDS));

  assign frame_done   = tx_active_q && (bit_cnt_q == 4'd9) &&
                        (baud_cnt_q == BaudW'(CLKS_PER_BIT - 1));
  // A new frame may be launched in the last cycle of the previous stop bit.
  assign uart_free    = !tx_active_q || frame_done;
  assign take_load    = load && request;
  assign refill       = (shift_cnt_q == 3'd0) && hold_full_q;
  assign block_done   = (state_q == StLf) && frame_done;
  // A start arriving in the completion cycle counts as already queued.
  assign start_queued = pending_q || start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (frame_done && chars_sent_q == CharW'(Chars)) state_d = StCr;
      StCr:   if (frame_done) state_d = StLf;
      StLf:   if (frame_done) state_d = start_queued ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    launch      = 1'b0;
    launch_data = 1'b0;
    launch_byte = 8'h00;
    unique case (state_q)
      StRun: begin
        if (frame_done && chars_sent_q == CharW'(Chars)) begin
          launch      = 1'b1;
          launch_byte = 8'h0D;
        end else if (uart_free && shift_cnt_q != 3'd0) begin
          launch      = 1'b1;
          launch_data = 1'b1;
          launch_byte = mix_to_ascii(shift_q[29:24]);
        end
      end
      StCr: begin
        if (frame_done) begin
          launch      = 1'b1;
          launch_byte = 8'h0A;
        end
      end
      default: ;
    endcase
  end

  // Block control: addresses, pending start, word and character counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop_q          <= 1'b0;
      pending_q       <= 1'b0;
      addressout_q    <= 12'd0;
      address_next_q  <= 12'd0;
      words_fetched_q <= '0;
      chars_sent_q    <= '0;
    end else begin
      stop_q <= 1'b0;
      if (state_q == StIdle) begin
        if (start) begin
          stop_q          <= 1'b1;
          addressout_q    <= addressin;
          words_fetched_q <= '0;
          chars_sent_q    <= '0;
        end
      end else if (block_done) begin
        if (start_queued) begin
          stop_q          <= 1'b1;
          pending_q       <= 1'b0;
          addressout_q    <= pending_q ? address_next_q : addressin;
          words_fetched_q <= '0;
          chars_sent_q    <= '0;
        end
      end else begin
        if (start && !pending_q) begin
          pending_q      <= 1'b1;
          address_next_q <= addressin;
        end
        if (take_load) begin
          addressout_q    <= addressout_q + 12'd1;
          words_fetched_q <= words_fetched_q + 1'b1;
        end
        if (launch_data) chars_sent_q <= chars_sent_q + 1'b1;
      end
    end
  end

  // Holding register and character shifter; the shifter refills as soon as
  // it empties so the next fetch overlaps transmission.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= 30'd0;
      hold_full_q <= 1'b0;
      shift_q     <= 30'd0;
      shift_cnt_q <= 3'd0;
    end else begin
      if (take_load) begin
        hold_q      <= in;
        hold_full_q <= 1'b1;
      end
      if (refill) begin
        shift_q     <= hold_q;
        shift_cnt_q <= 3'd5;
        hold_full_q <= 1'b0;
      end else if (launch_data) begin
        shift_q     <= {shift_q[23:0], 6'd0};
        shift_cnt_q <= shift_cnt_q - 3'd1;
      end
    end
  end

  // 8N1 transmitter. Data shifts in ones from the top, so after the eighth
  // data bit the next bit out is the stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_active_q <= 1'b0;
      tx_q        <= 1'b1;
      bit_cnt_q   <= 4'd0;
      baud_cnt_q  <= '0;
      data_q      <= 8'hFF;
    end else if (launch) begin
      tx_active_q <= 1'b1;
      tx_q        <= 1'b0;
      bit_cnt_q   <= 4'd0;
      baud_cnt_q  <= '0;
      data_q      <= launch_byte;
    end else if (tx_active_q) begin
      if (baud_cnt_q == BaudW'(CLKS_PER_BIT - 1)) begin
        baud_cnt_q <= '0;
        if (bit_cnt_q == 4'd9) begin
          tx_active_q <= 1'b0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          tx_q      <= data_q[0];
          data_q    <= {1'b1, data_q[7:1]};
        end
      end else begin
        baud_cnt_q <= baud_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_out_line.sv
module tb_out_line;

  localparam int Words = 2;
  localparam int Cpb   = 4;
  localparam int Frame = 10 * Cpb;

  logic        clk, reset, start, load;
  logic [11:0] addressin, addressout;
  logic [29:0] mem_word;
  logic        request, stop, busy, tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [29:0] mem [0:4095];
  logic [7:0]  exp_bytes [$];
  logic [11:0] exp_addr [$];
  int          frame_starts [$];
  int          stop_log [$];
  int          withhold = 0;
  bit          arm_withhold = 0;
  string       code_tbl = " ABCDEFGHI?JKLMNOPQR??STUVWXYZ0123456789.,()+-*/=$<>@;:'????????";

  out_line #(.WORDS(Words), .CLKS_PER_BIT(Cpb)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addressin (addressin),
    .in        (mem_word),
    .load      (load),
    .addressout(addressout),
    .request   (request),
    .stop      (stop),
    .busy      (busy),
    .tx        (tx)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] model(input logic [5:0] code);
    return code_tbl[int'(code)];
  endfunction

  function automatic logic [29:0] pack(input int a, b, c, d, e);
    return {6'(a), 6'(b), 6'(c), 6'(d), 6'(e)};
  endfunction

  task automatic push_block(input logic [11:0] addr);
    logic [11:0] a;
    logic [29:0] w;
    for (int i = 0; i < Words; i++) begin
      a = addr + 12'(i);
      w = mem[a];
      exp_addr.push_back(a);
      for (int f = 0; f < 5; f++) exp_bytes.push_back(model(6'(w >> (24 - 6 * f))));
    end
    exp_bytes.push_back(8'h0D);
    exp_bytes.push_back(8'h0A);
  endtask

  task automatic do_start(input logic [11:0] addr, output int t);
    @(negedge clk);
    start = 1;
    addressin = addr;
    t = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(input string name, output int t_idle);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    t_idle = cyc;
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s idle timeout busy=%b", name, busy);
    end
  endtask

  task automatic wait_frames(input string name, input int n);
    int k = 0;
    while (frame_starts.size() < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (frame_starts.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s frame timeout got=%0d need=%0d", name, frame_starts.size(), n);
    end
  endtask

  task automatic wait_cyc(input int t);
    int k = 0;
    while (cyc < t && k < 5000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic clear_logs();
    frame_starts.delete();
    stop_log.delete();
  endtask

  // Memory responder: answers each request after a cycle, checks addressout.
  initial begin
    int lat = 0;
    logic [11:0] ea;
    load = 0;
    mem_word = '0;
    forever begin
      @(negedge clk);
      load = 0;
      if (reset) begin
        lat = 0;
      end else if (request === 1'b1) begin
        if (withhold > 0) begin
          withhold--;
        end else if (lat >= 1) begin
          checks++;
          if (exp_addr.size() == 0) begin
            errors++;
            $display("FAIL addr unexpected request addressout=%0d", addressout);
          end else begin
            ea = exp_addr.pop_front();
            if (addressout !== ea) begin
              errors++;
              $display("FAIL addr got=%0d exp=%0d", addressout, ea);
            end
          end
          load = 1;
          mem_word = mem[addressout];
          lat = 0;
          if (arm_withhold) begin
            withhold = 300;
            arm_withhold = 0;
          end
        end else begin
          lat++;
        end
      end
    end
  end

  // UART receiver: captures 40 samples per frame and checks against scoreboard.
  initial begin
    bit rx_on = 0;
    int rx_n = 0;
    logic [39:0] bits;
    logic [7:0] b, e;
    bit shape_ok;
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_on = 0;
      end else if (!rx_on) begin
        if (tx === 1'b0) begin
          rx_on = 1;
          rx_n = 1;
          bits[0] = 1'b0;
          frame_starts.push_back(cyc);
        end
      end else begin
        bits[rx_n] = tx;
        rx_n++;
        if (rx_n == Frame) begin
          rx_on = 0;
          shape_ok = (bits[0] === 1'b0) && (bits[36] === 1'b1);
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < Cpb; j++)
              if (bits[k * Cpb + j] !== bits[k * Cpb]) shape_ok = 0;
          for (int k = 0; k < 8; k++) b[k] = bits[(k + 1) * Cpb];
          checks++;
          if (!shape_ok) begin
            errors++;
            $display("FAIL frame_shape bits=%h", bits);
          end
          checks++;
          if (exp_bytes.size() == 0) begin
            errors++;
            $display("FAIL tx_byte unexpected got=%h", b);
          end else begin
            e = exp_bytes.pop_front();
            if (b !== e) begin
              errors++;
              $display("FAIL tx_byte got=%h exp=%h", b, e);
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (stop === 1'b1) stop_log.push_back(cyc);
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || request !== 1'b0 || stop !== 1'b0 ||
        addressout !== 12'd0) begin
      errors++;
      $display("FAIL reset_state tx=%b busy=%b req=%b stop=%b addr=%0d exp=1 0 0 0 0",
               tx, busy, request, stop, addressout);
    end
    reset = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_block();
    int t0, t_idle;
    bit gaps_ok = 1;
    logic [7:0] lit [12] = '{8'h41, 8'h42, 8'h43, 8'h20, 8'h30, 8'h31, 8'h32, 8'h33,
                             8'h34, 8'h35, 8'h0D, 8'h0A};
    clear_logs();
    mem[100] = pack(1, 2, 3, 0, 30);
    mem[101] = pack(31, 32, 33, 34, 35);
    exp_addr.push_back(12'd100);
    exp_addr.push_back(12'd101);
    foreach (lit[i]) exp_bytes.push_back(lit[i]);
    do_start(12'd100, t0);
    wait_idle("basic", t_idle);
    checks++;
    if (stop_log.size() != 1 || stop_log[0] != t0 + 1) begin
      errors++;
      $display("FAIL basic_stop count=%0d first=%0d exp_at=%0d", stop_log.size(),
               (stop_log.size() > 0) ? stop_log[0] : -1, t0 + 1);
    end
    checks++;
    if (frame_starts.size() != 12) begin
      errors++;
      $display("FAIL basic_frames got=%0d exp=12", frame_starts.size());
    end else begin
      for (int i = 1; i < 12; i++)
        if (frame_starts[i] - frame_starts[i-1] != Frame) gaps_ok = 0;
      checks++;
      if (!gaps_ok) begin
        errors++;
        $display("FAIL basic_back_to_back frames not spaced %0d cycles", Frame);
      end
      checks++;
      if (t_idle != frame_starts[11] + Frame) begin
        errors++;
        $display("FAIL basic_busy_fall got=%0d exp=%0d", t_idle, frame_starts[11] + Frame);
      end
    end
    checks++;
    if (exp_bytes.size() != 0 || exp_addr.size() != 0) begin
      errors++;
      $display("FAIL basic_drain bytes_left=%0d addr_left=%0d exp=0 0",
               exp_bytes.size(), exp_addr.size());
    end
  endtask

  task automatic test_code_map();
    int t0, t_idle;
    logic [7:0] lit [12] = '{8'h3F, 8'h2D, 8'h3D, 8'h27, 8'h3F, 8'h2E, 8'h2C, 8'h28,
                             8'h29, 8'h2B, 8'h0D, 8'h0A};
    clear_logs();
    mem[300] = pack(10, 45, 48, 55, 63);
    mem[301] = pack(40, 41, 42, 43, 44);
    exp_addr.push_back(12'd300);
    exp_addr.push_back(12'd301);
    foreach (lit[i]) exp_bytes.push_back(lit[i]);
    do_start(12'd300, t0);
    wait_idle("codemap", t_idle);
    checks++;
    if (exp_bytes.size() != 0 || frame_starts.size() != 12) begin
      errors++;
      $display("FAIL codemap_drain bytes_left=%0d frames=%0d exp=0 12",
               exp_bytes.size(), frame_starts.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, t_idle, drops = 0, k = 0;
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      mem[400 + i] = 30'($urandom);
      mem[200 + i] = 30'($urandom);
    end
    push_block(12'd400);
    push_block(12'd200);
    do_start(12'd400, t0);
    wait_frames("b2b", 3);
    do_start(12'd200, t1);
    wait_frames("b2b", 5);
    do_start(12'd999, t1);
    while (frame_starts.size() < 24 && k < 5000) begin
      @(negedge clk);
      if (busy !== 1'b1) drops++;
      k++;
    end
    wait_idle("b2b", t_idle);
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL b2b_busy_held drops=%0d exp=0", drops);
    end
    checks++;
    if (frame_starts.size() != 24 || stop_log.size() != 2) begin
      errors++;
      $display("FAIL b2b_counts frames=%0d stops=%0d exp=24 2",
               frame_starts.size(), stop_log.size());
    end else begin
      checks++;
      if (stop_log[1] != frame_starts[11] + Frame) begin
        errors++;
        $display("FAIL b2b_stop_at got=%0d exp=%0d", stop_log[1], frame_starts[11] + Frame);
      end
      checks++;
      if (frame_starts[12] - frame_starts[11] >= 2 * Frame) begin
        errors++;
        $display("FAIL b2b_gap got=%0d exp<%0d", frame_starts[12] - frame_starts[11],
                 2 * Frame);
      end
    end
    checks++;
    if (exp_addr.size() != 0 || exp_bytes.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain addr_left=%0d bytes_left=%0d exp=0 0",
               exp_addr.size(), exp_bytes.size());
    end
  endtask

  task automatic test_start_at_completion();
    int t0, t1, t_idle, s;
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      mem[600 + i] = 30'($urandom);
      mem[700 + i] = 30'($urandom);
    end
    push_block(12'd600);
    push_block(12'd700);
    do_start(12'd600, t0);
    wait_frames("cmpl", 12);
    s = frame_starts[11];
    wait_cyc(s + Frame - 1);
    start = 1;
    addressin = 12'd700;
    @(negedge clk);
    start = 0;
    wait_idle("cmpl", t_idle);
    checks++;
    if (stop_log.size() != 2 || stop_log[stop_log.size() - 1] != s + Frame) begin
      errors++;
      $display("FAIL cmpl_stop count=%0d last=%0d exp=2 at %0d", stop_log.size(),
               (stop_log.size() > 0) ? stop_log[stop_log.size() - 1] : -1, s + Frame);
    end
    checks++;
    if (frame_starts.size() != 24 || t_idle != frame_starts[frame_starts.size() - 1] + Frame)
    begin
      errors++;
      $display("FAIL cmpl_second_block frames=%0d idle_at=%0d exp=24 frames",
               frame_starts.size(), t_idle);
    end
  endtask

  task automatic test_late_load();
    int t0, t_idle;
    clear_logs();
    mem[500] = 30'($urandom);
    mem[501] = 30'($urandom);
    push_block(12'd500);
    arm_withhold = 1;
    do_start(12'd500, t0);
    wait_cyc(t0 + 260);
    checks++;
    if (request !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL late_wait req=%b tx=%b exp=1 1", request, tx);
    end
    wait_idle("late", t_idle);
    checks++;
    if (frame_starts.size() != 12 || exp_bytes.size() != 0) begin
      errors++;
      $display("FAIL late_frames got=%0d bytes_left=%0d exp=12 0",
               frame_starts.size(), exp_bytes.size());
    end else begin
      checks++;
      if (frame_starts[5] - frame_starts[4] <= Frame) begin
        errors++;
        $display("FAIL late_gap got=%0d exp>%0d", frame_starts[5] - frame_starts[4], Frame);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0, t_idle, s;
    clear_logs();
    mem[4095] = pack(5, 6, 7, 8, 9);
    mem[0]    = pack(36, 37, 38, 39, 0);
    push_block(12'd4095);
    do_start(12'd4095, t0);
    wait_frames("rstmid", 1);
    s = (frame_starts.size() > 0) ? frame_starts[0] : cyc;
    wait_cyc(s + 13);
    #2 reset = 1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || request !== 1'b0 || stop !== 1'b0 ||
        addressout !== 12'd0) begin
      errors++;
      $display("FAIL reset_async tx=%b busy=%b req=%b stop=%b addr=%0d exp=1 0 0 0 0",
               tx, busy, request, stop, addressout);
    end
    @(negedge clk);
    @(negedge clk);
    exp_bytes.delete();
    exp_addr.delete();
    reset = 0;
    repeat (2) @(negedge clk);
    clear_logs();
    push_block(12'd4095);
    do_start(12'd4095, t0);
    wait_idle("rstmid", t_idle);
    checks++;
    if (stop_log.size() != 1 || frame_starts.size() != 12 || exp_bytes.size() != 0 ||
        exp_addr.size() != 0) begin
      errors++;
      $display("FAIL restart stops=%0d frames=%0d bytes_left=%0d addr_left=%0d exp=1 12 0 0",
               stop_log.size(), frame_starts.size(), exp_bytes.size(), exp_addr.size());
    end
  endtask

  initial begin
    reset = 1;
    start = 0;
    addressin = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 30'($urandom);
    test_reset();
    test_basic_block();
    test_code_map();
    test_back_to_back();
    test_start_at_completion();
    test_late_load();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
